// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: keeps the PC, reads the synchronous instruction ROM, and issues
// decoded fields to the decoder with a valid/stall handshake, branch redirect and HALT stop.
module instr_fetch_unit #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          RESET_PC    = 0,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
    input  logic                  ClockInput,
    input  logic                  ResetInput,
    output logic [ADDR_WIDTH-1:0] InstrAddressOutput,
    output logic                  InstrReadEnableOutput,
    input  logic [21:0]           InstrDataInput,
    input  logic                  StallInput,
    input  logic                  BranchValidInput,
    input  logic [ADDR_WIDTH-1:0] BranchTargetInput,
    output logic [4:0]            OpecodeOutput,
    output logic                  AddressingModeOutput,
    output logic [15:0]           OperandOutput,
    output logic                  InstrValidOutput,
    output logic [ADDR_WIDTH-1:0] ProgramCounterOutput,
    output logic                  HaltedOutput
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_ISSUE, S_HALTED} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic                  capture;
    logic                  consume;
    logic                  halt_now;
    logic                  redirect;

    assign InstrAddressOutput    = pc;
    assign InstrReadEnableOutput = (state == S_REQ) & ~ResetInput;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        consume   = 1'b0;
        halt_now  = 1'b0;
        redirect  = BranchValidInput & (state != S_HALTED);
        case (state)
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT: begin
                state_nxt = S_ISSUE;
                capture   = 1'b1;
            end
            S_ISSUE: begin
                if (!StallInput) begin
                    consume = 1'b1;
                    if (OpecodeOutput == HALT_OPCODE) begin
                        halt_now  = 1'b1;
                        state_nxt = S_HALTED;
                    end else begin
                        pc_nxt    = pc + ADDR_WIDTH'(1);
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_REQ;
        endcase
        // A redirect discards whatever is in flight or waiting, including a HALT.
        if (redirect) begin
            state_nxt = S_REQ;
            pc_nxt    = BranchTargetInput;
            capture   = 1'b0;
            consume   = 1'b0;
            halt_now  = 1'b0;
        end
    end

    always_ff @(posedge ClockInput) begin
        if (ResetInput) begin
            state                <= S_REQ;
            pc                   <= ADDR_WIDTH'(RESET_PC);
            OpecodeOutput        <= '0;
            AddressingModeOutput <= 1'b0;
            OperandOutput        <= '0;
            InstrValidOutput     <= 1'b0;
            ProgramCounterOutput <= '0;
            HaltedOutput         <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                OpecodeOutput        <= InstrDataInput[21:17];
                AddressingModeOutput <= InstrDataInput[16];
                OperandOutput        <= InstrDataInput[15:0];
                ProgramCounterOutput <= pc;
                InstrValidOutput     <= 1'b1;
            end else if (consume || redirect) begin
                InstrValidOutput <= 1'b0;
            end
            if (halt_now) begin
                HaltedOutput <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit with a one-cycle-latency ROM model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        rd;
    logic [21:0] rdata;
    logic        stall;
    logic        bv;
    logic [7:0]  tgt;
    logic [4:0]  op;
    logic        mode;
    logic [15:0] opr;
    logic        vld;
    logic [7:0]  pcout;
    logic        halted;

    logic [21:0] rom [0:255];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(0), .HALT_OPCODE(5'b11111)) dut (
        .ClockInput            (clk),
        .ResetInput            (rst),
        .InstrAddressOutput    (addr),
        .InstrReadEnableOutput (rd),
        .InstrDataInput        (rdata),
        .StallInput            (stall),
        .BranchValidInput      (bv),
        .BranchTargetInput     (tgt),
        .OpecodeOutput         (op),
        .AddressingModeOutput  (mode),
        .OperandOutput         (opr),
        .InstrValidOutput      (vld),
        .ProgramCounterOutput  (pcout),
        .HaltedOutput          (halted)
    );

    // Synchronous ROM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd) rdata <= rom[addr];
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        bv;
        logic [7:0]  tgt;
        logic [40:0] exp;   // {rd, addr, vld, op, mode, opr, pcout, halted}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [7:0] t,
                                input logic e_rd, input logic [7:0] e_addr, input logic e_vld,
                                input logic [4:0] e_op, input logic e_mode, input logic [15:0] e_opr,
                                input logic [7:0] e_pc, input logic e_halt);
        vec_t v;
        v.rst   = r;
        v.stall = s;
        v.bv    = b;
        v.tgt   = t;
        v.exp   = {e_rd, e_addr, e_vld, e_op, e_mode, e_opr, e_pc, e_halt};
        return v;
    endfunction

    function automatic logic [40:0] actual();
        return {rd, addr, vld, op, mode, opr, pcout, halted};
    endfunction

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (rd,addr,vld,op,mode,opr,pc,halt)", name, act, exp);
        end
    endtask

    // Inputs are held across one rising edge; reset and branch are single-cycle pulses.
    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rst   = tbl[i].rst;
            stall = tbl[i].stall;
            bv    = tbl[i].bv;
            tgt   = tbl[i].tgt;
            @(posedge clk);
            #1;
            rst = 1'b0;
            bv  = 1'b0;
            #1;
            check($sformatf("row%0d", i), actual(), tbl[i].exp);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 22'h0;
        rom[8'h00] = 22'h000005;
        rom[8'h01] = 22'h0A0010;
        rom[8'h02] = 22'h040002;
        rom[8'h03] = 22'h3E0007;
        rom[8'h10] = 22'h0C0ABC;
        rom[8'h40] = 22'h051234;
        rom[8'hFF] = 22'h06BEEF;

        // Phase A: fetch, stall, branch in WAIT, branch over stall, PC wrap, HALT.
        tbl.push_back(mk(1,0,0,8'h00, 1,8'h00,0,5'h00,0,16'h0000,8'h00,0)); // 0 reset
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,0,5'h00,0,16'h0000,8'h00,0)); // 1 wait
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,1,5'h00,0,16'h0005,8'h00,0)); // 2 issue ROM[0]
        tbl.push_back(mk(0,0,0,8'h00, 1,8'h01,0,5'h00,0,16'h0005,8'h00,0)); // 3 consume
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h01,0,5'h00,0,16'h0005,8'h00,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h01,1,5'h05,0,16'h0010,8'h01,0)); // 5 issue ROM[1]
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,1,0,8'h00, 0,8'h01,1,5'h05,0,16'h0010,8'h01,0)); // 6-9 stall
        tbl.push_back(mk(0,0,0,8'h00, 1,8'h02,0,5'h05,0,16'h0010,8'h01,0)); // 10
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h02,0,5'h05,0,16'h0010,8'h01,0)); // 11 wait
        tbl.push_back(mk(0,0,1,8'h40, 1,8'h40,0,5'h05,0,16'h0010,8'h01,0)); // 12 branch in WAIT
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h40,0,5'h05,0,16'h0010,8'h01,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h40,1,5'h02,1,16'h1234,8'h40,0)); // 14
        tbl.push_back(mk(0,1,1,8'hFF, 1,8'hFF,0,5'h02,1,16'h1234,8'h40,0)); // 15 branch beats stall
        tbl.push_back(mk(0,0,0,8'h00, 0,8'hFF,0,5'h02,1,16'h1234,8'h40,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'hFF,1,5'h03,0,16'hBEEF,8'hFF,0)); // 17
        tbl.push_back(mk(0,0,0,8'h00, 1,8'h00,0,5'h03,0,16'hBEEF,8'hFF,0)); // 18 wrap to 0
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,0,5'h03,0,16'hBEEF,8'hFF,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,1,5'h00,0,16'h0005,8'h00,0)); // 20
        tbl.push_back(mk(0,0,1,8'h03, 1,8'h03,0,5'h00,0,16'h0005,8'h00,0)); // 21 branch beats consume
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h03,0,5'h00,0,16'h0005,8'h00,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h03,1,5'h1F,0,16'h0007,8'h03,0)); // 23 HALT issued
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h03,1,5'h1F,0,16'h0007,8'h03,0));
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h03,1,5'h1F,0,16'h0007,8'h03,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h03,0,5'h1F,0,16'h0007,8'h03,1)); // 26 halted
        // Phase B: reset out of HALTED, HALT cancelled by branch, reset during stalled ISSUE.
        tbl.push_back(mk(1,0,0,8'h00, 1,8'h00,0,5'h00,0,16'h0000,8'h00,0)); // 27
        tbl.push_back(mk(0,0,1,8'h03, 1,8'h03,0,5'h00,0,16'h0000,8'h00,0)); // 28 branch in REQ
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h03,0,5'h00,0,16'h0000,8'h00,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h03,1,5'h1F,0,16'h0007,8'h03,0)); // 30
        tbl.push_back(mk(0,0,1,8'h10, 1,8'h10,0,5'h1F,0,16'h0007,8'h03,0)); // 31 no halt
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h10,0,5'h1F,0,16'h0007,8'h03,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h10,1,5'h06,0,16'h0ABC,8'h10,0)); // 33
        tbl.push_back(mk(0,1,0,8'h00, 0,8'h10,1,5'h06,0,16'h0ABC,8'h10,0));
        tbl.push_back(mk(1,1,0,8'h00, 1,8'h00,0,5'h00,0,16'h0000,8'h00,0)); // 35 reset in ISSUE
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,0,5'h00,0,16'h0000,8'h00,0));
        tbl.push_back(mk(0,0,0,8'h00, 0,8'h00,1,5'h00,0,16'h0005,8'h00,0)); // 37

        rst   = 1'b1;
        stall = 1'b0;
        bv    = 1'b0;
        tgt   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // While reset is held the strobe stays low and everything reads as reset values.
        check("reset_hold", actual(), {1'b0, 8'h00, 1'b0, 5'h00, 1'b0, 16'h0000, 8'h00, 1'b0});

        run_rows(0, 26);

        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                bv  = 1'b1;
                tgt = 8'h55;
            end
            @(posedge clk);
            #1;
            bv = 1'b0;
            #1;
            check($sformatf("halted_c%0d", c), actual(),
                  {1'b0, 8'h03, 1'b0, 5'h1F, 1'b0, 16'h0007, 8'h03, 1'b1});
        end

        run_rows(27, tbl.size() - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
